// File: rtl/c3aibadapt_avmm_mwfifo_ptr.sv
// Pointer, occupancy and flag controller for the multi-word-write FIFO.
// Decides write acceptance, advances both pointers, and registers the
// status and sticky error flags from the next-cycle occupancy.
module c3aibadapt_avmm_mwfifo_ptr #(
    parameter int AWIDTH = 6,
    parameter int WLANES = 8,
    parameter int CWIDTH = $clog2(WLANES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst_n,
    input  logic              wr_en,
    input  logic [CWIDTH-1:0] wr_cnt,
    input  logic              rd_en,
    input  logic [AWIDTH:0]   r_pempty,
    input  logic [AWIDTH:0]   r_pfull,
    input  logic              r_stop_write,
    input  logic              clr_err,
    output logic [AWIDTH-1:0] wr_ptr,
    output logic [AWIDTH-1:0] rd_ptr,
    output logic              wr_acc,
    output logic [AWIDTH:0]   numdata,
    output logic              empty,
    output logic              pempty,
    output logic              full,
    output logic              pfull,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              empty_q, pempty_q, full_q, pfull_q;
    logic              overflow_q, underflow_q;

    logic [AWIDTH:0]   space;
    logic [AWIDTH:0]   cnt_ext;
    logic [AWIDTH:0]   wr_add;
    logic [AWIDTH+1:0] sum;
    logic              rd_acc, wreq, fits, ovf_set, unf_set;

    // Next-state computation: acceptance, saturated occupancy, pointers.
    // NOTE: every signal gets a value on every path through this block,
    // so no latch is inferred.
    always_comb begin
        space    = (AWIDTH+1)'(DEPTH) - count_q;
        cnt_ext  = (AWIDTH+1)'(wr_cnt);
        rd_acc   = rd_en && (count_q != '0);
        wreq     = wr_en && (wr_cnt != '0);
        // Space comes from the registered count only; a same-cycle pop
        // does not make room for the same-cycle write.
        fits     = (cnt_ext <= space);
        wr_acc   = wreq && (fits || !r_stop_write);
        wr_add   = wr_acc ? cnt_ext : '0;
        sum      = (AWIDTH+2)'(count_q) + (AWIDTH+2)'(wr_add) - (AWIDTH+2)'(rd_acc);
        count_d  = (sum > (AWIDTH+2)'(DEPTH)) ? (AWIDTH+1)'(DEPTH) : sum[AWIDTH:0];
        wr_ptr_d = wr_ptr_q + wr_add[AWIDTH-1:0];
        // In overwrite mode the head is re-derived from the tail so that
        // any words pushed past DEPTH silently drop the oldest entries.
        rd_ptr_d = r_stop_write ? (rd_ptr_q + AWIDTH'(rd_acc))
                                : (wr_ptr_d - count_d[AWIDTH-1:0]);
        ovf_set  = wreq && !fits;
        unf_set  = rd_en && (count_q == '0);
    end

    // State and flag registers; sync reset outranks all traffic.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            pempty_q    <= 1'b1;
            full_q      <= 1'b0;
            pfull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!srst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            pempty_q    <= 1'b1;
            full_q      <= 1'b0;
            pfull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == (AWIDTH+1)'(DEPTH));
            pempty_q    <= (count_d <= r_pempty);
            pfull_q     <= (count_d >= r_pfull);
            overflow_q  <= ovf_set || (overflow_q && !clr_err);
            underflow_q <= unf_set || (underflow_q && !clr_err);
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign numdata   = count_q;
    assign empty     = empty_q;
    assign pempty    = pempty_q;
    assign full      = full_q;
    assign pfull     = pfull_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/c3aibadapt_avmm_mwfifo.sv
// Single-clock FIFO: up to WLANES words written per cycle, one word popped
// per cycle, show-ahead read data. Holds the storage array and lane writer;
// pointer and flag control lives in c3aibadapt_avmm_mwfifo_ptr.
module c3aibadapt_avmm_mwfifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 6,
    parameter int WLANES = 8,
    localparam int CWIDTH = $clog2(WLANES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     srst_n,
    input  logic                     wr_en,
    input  logic [CWIDTH-1:0]        wr_cnt,
    input  logic [WLANES*DWIDTH-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [AWIDTH:0]          r_pempty,
    input  logic [AWIDTH:0]          r_pfull,
    input  logic                     r_stop_write,
    input  logic                     clr_err,
    output logic [DWIDTH-1:0]        rd_data,
    output logic [AWIDTH:0]          numdata,
    output logic                     empty,
    output logic                     pempty,
    output logic                     full,
    output logic                     pfull,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic              wr_acc;
    logic [AWIDTH-1:0] lane_addr [WLANES];
    logic              lane_we   [WLANES];

    c3aibadapt_avmm_mwfifo_ptr #(
        .AWIDTH (AWIDTH),
        .WLANES (WLANES),
        .CWIDTH (CWIDTH)
    ) u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .srst_n       (srst_n),
        .wr_en        (wr_en),
        .wr_cnt       (wr_cnt),
        .rd_en        (rd_en),
        .r_pempty     (r_pempty),
        .r_pfull      (r_pfull),
        .r_stop_write (r_stop_write),
        .clr_err      (clr_err),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .wr_acc       (wr_acc),
        .numdata      (numdata),
        .empty        (empty),
        .pempty       (pempty),
        .full         (full),
        .pfull        (pfull),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Per-lane target address (wraps modulo DEPTH) and write strobe.
    always_comb begin
        for (int i = 0; i < WLANES; i++) begin
            lane_addr[i] = wr_ptr + AWIDTH'(i);
            lane_we[i]   = wr_acc && (CWIDTH'(i) < wr_cnt);
        end
    end

    // Storage array; lane i lands at wr_ptr+i when the write is accepted.
    // NOTE: the array is deliberately cleared by both resets so that the
    // show-ahead output reads zero after reset; this costs a reset net on
    // every storage bit and rules out a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
        end else if (!srst_n) begin
            for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
        end else begin
            for (int i = 0; i < WLANES; i++) begin
                if (lane_we[i]) mem_q[lane_addr[i]] <= wr_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: tb/tb_c3aibadapt_avmm_mwfifo.sv
// Self-checking bench for c3aibadapt_avmm_mwfifo (DWIDTH=8, AWIDTH=4, WLANES=8).
// A queue holds the words the FIFO should contain; pops compare the head.
module tb_c3aibadapt_avmm_mwfifo;

    localparam int DWIDTH = 8;
    localparam int AWIDTH = 4;
    localparam int WLANES = 8;
    localparam int CWIDTH = $clog2(WLANES + 1);
    localparam int DEPTH  = 1 << AWIDTH;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     srst_n = 1'b1;
    logic                     wr_en = 1'b0;
    logic [CWIDTH-1:0]        wr_cnt = '0;
    logic [WLANES*DWIDTH-1:0] wr_data = '0;
    logic                     rd_en = 1'b0;
    logic [AWIDTH:0]          r_pempty = 5'd2;
    logic [AWIDTH:0]          r_pfull = 5'd14;
    logic                     r_stop_write = 1'b1;
    logic                     clr_err = 1'b0;
    logic [DWIDTH-1:0]        rd_data;
    logic [AWIDTH:0]          numdata;
    logic                     empty, pempty, full, pfull, overflow, underflow;

    c3aibadapt_avmm_mwfifo #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WLANES (WLANES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .srst_n       (srst_n),
        .wr_en        (wr_en),
        .wr_cnt       (wr_cnt),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .r_pempty     (r_pempty),
        .r_pfull      (r_pfull),
        .r_stop_write (r_stop_write),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .numdata      (numdata),
        .empty        (empty),
        .pempty       (pempty),
        .full         (full),
        .pfull        (pfull),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // wr_cnt above WLANES is an illegal request.
    always @(posedge clk) begin
        if (wr_en) assert (wr_cnt <= CWIDTH'(WLANES)) else $error("illegal wr_cnt %0d", wr_cnt);
    end

    logic [DWIDTH-1:0] exp_q[$];
    bit                exp_ovf = 1'b0;
    bit                exp_unf = 1'b0;
    int                n_checks = 0;
    int                n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_status();
        int sz;
        sz = exp_q.size();
        check("numdata",   32'(numdata),   32'(sz));
        check("empty",     32'(empty),     32'(sz == 0));
        check("full",      32'(full),      32'(sz == DEPTH));
        check("pempty",    32'(pempty),    32'(sz <= int'(r_pempty)));
        check("pfull",     32'(pfull),     32'(sz >= int'(r_pfull)));
        check("overflow",  32'(overflow),  32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_unf));
        if (sz > 0) check("head", 32'(rd_data), 32'(exp_q[0]));
    endtask

    // One clock of traffic; the model is updated from what was driven.
    task automatic step(input bit we, input int cnt, input logic [63:0] data, input bit re,
                        input bit clr = 1'b0, input bit srst = 1'b0);
        int space;
        bit wreq, ovf_set, unf_set;
        wr_en   = we;
        wr_cnt  = CWIDTH'(cnt);
        wr_data = data;
        rd_en   = re;
        clr_err = clr;
        srst_n  = !srst;
        if (re && !srst && exp_q.size() > 0) check("pop_data", 32'(rd_data), 32'(exp_q[0]));
        @(posedge clk);
        #1;
        if (srst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            space   = DEPTH - exp_q.size();
            wreq    = we && (cnt != 0);
            ovf_set = wreq && (cnt > space);
            unf_set = re && (exp_q.size() == 0);
            if (re && exp_q.size() > 0) void'(exp_q.pop_front());
            if (wreq && (cnt <= space || !r_stop_write)) begin
                for (int i = 0; i < cnt; i++) exp_q.push_back(data[i*8 +: 8]);
            end
            while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            exp_ovf = ovf_set || (exp_ovf && !clr);
            exp_unf = unf_set || (exp_unf && !clr);
        end
        wr_en   = 1'b0;
        wr_cnt  = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        srst_n  = 1'b1;
        check_status();
    endtask

    task automatic wr_seq(input int base, input int cnt, input bit re = 1'b0);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < cnt; i++) d[i*8 +: 8] = 8'(base + i);
        step(1'b1, cnt, d, re);
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 64'd0, 1'b1);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_status();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] d;
        repeat (3) @(posedge clk);
        #1;
        hard_reset();

        // Multi-word writes, then drain in order.
        wr_seq(8'h10, 8);
        wr_seq(8'h20, 3);
        check("multi_numdata", 32'(numdata), 32'd11);
        pop(11);
        check("multi_empty", 32'(empty), 32'd1);

        // Move both pointers to 13, then a write that wraps the array.
        wr_seq(8'h30, 2);
        pop(2);
        wr_seq(8'hB0, 8);
        check("wrap_head", 32'(rd_data), 32'hB0);
        pop(8);

        // Reject mode: full FIFO, same-cycle pop does not make room.
        r_stop_write = 1'b1;
        wr_seq(8'h40, 8);
        wr_seq(8'h48, 8);
        check("rej_full", 32'(full), 32'd1);
        step(1'b1, 1, 64'hEE, 1'b1);
        check("rej_numdata", 32'(numdata), 32'd15);
        check("rej_overflow", 32'(overflow), 32'd1);
        step(1'b0, 0, 64'd0, 1'b0, 1'b1);
        check("rej_clr", 32'(overflow), 32'd0);
        // Set and clear in the same cycle: the set wins.
        step(1'b1, 2, 64'hCCDD, 1'b0, 1'b1);
        check("set_wins", 32'(overflow), 32'd1);
        step(1'b0, 0, 64'd0, 1'b0, 1'b1);
        pop(15);

        // Overwrite mode: 14 stored, 4 more discards the two oldest.
        hard_reset();
        r_stop_write = 1'b0;
        wr_seq(8'h00, 8);
        wr_seq(8'h08, 6);
        wr_seq(8'hA0, 4);
        check("ovw_numdata", 32'(numdata), 32'd16);
        check("ovw_head", 32'(rd_data), 32'h02);
        check("ovw_overflow", 32'(overflow), 32'd1);
        pop(16);
        r_stop_write = 1'b1;

        // Underflow on empty; the head must not have moved.
        step(1'b0, 0, 64'd0, 1'b1);
        check("unf_flag", 32'(underflow), 32'd1);
        wr_seq(8'h55, 1);
        check("unf_head", 32'(rd_data), 32'h55);
        step(1'b0, 0, 64'd0, 1'b0, 1'b1);

        // Synchronous reset mid-burst with 9 stored; its cycle's write is lost.
        wr_seq(8'h60, 8);
        check("srst_pre", 32'(numdata), 32'd9);
        step(1'b1, 3, 64'h777777, 1'b1, 1'b0, 1'b1);
        check("srst_numdata", 32'(numdata), 32'd0);
        check("srst_rd_data", 32'(rd_data), 32'h0);

        // Mixed random traffic in both modes.
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) begin
                r_stop_write = 1'($urandom_range(0, 1));
                r_pempty     = 5'($urandom_range(0, DEPTH));
                r_pfull      = 5'($urandom_range(0, DEPTH));
            end
            d = {$urandom, $urandom};
            step($urandom_range(0, 2) != 0, $urandom_range(0, WLANES), d,
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
